// File: rtl/mux_rr_reg.sv
// Registered N-way mux with fixed-select or round-robin arbitration.
// A single output slot with valid/ready handshake that reloads on the same edge it drains.
module mux_rr_reg #(
    parameter int width  = 4,
    parameter int swidth = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**swidth)*width-1:0]  i,
    input  logic [(2**swidth)-1:0]        in_valid,
    output logic [(2**swidth)-1:0]        in_ready,
    input  logic [swidth-1:0]             sel,
    input  logic                          mode,
    output logic [width-1:0]              o,
    output logic [swidth-1:0]             o_ch,
    output logic                          o_valid,
    input  logic                          o_ready
);
    localparam int N = 2**swidth;

    logic [swidth-1:0] ptr;
    logic [swidth-1:0] g;
    logic [swidth-1:0] idx;
    logic              found;
    logic              load_en;
    logic              xfer;

    // Grant selection. In fixed mode the grant exists regardless of in_valid,
    // so in_ready there does not depend on in_valid.
    always_comb begin
        load_en = (!o_valid || o_ready) && !rst;
        g       = sel;
        found   = 1'b1;
        idx     = '0;
        if (mode) begin
            g     = ptr;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = ptr + swidth'(k);
                if (!found && in_valid[idx]) begin
                    g     = idx;
                    found = 1'b1;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_rdy
            assign in_ready[k] = found && load_en && (g == swidth'(k));
        end
    endgenerate

    assign xfer = in_valid[g] && in_ready[g];

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_ch    <= '0;
            o_valid <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            o       <= i[g*width +: width];
            o_ch    <= g;
            o_valid <= 1'b1;
            if (mode)
                ptr <= g + swidth'(1);
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: in_ready checked per step, output beats scored
// through a queue of expected {o, o_ch} popped whenever the DUT hands one off.
module tb_mux_rr_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [2:0]  sel;
    logic        mode;
    logic [3:0]  o;
    logic [2:0]  o_ch;
    logic        o_valid;
    logic        o_ready;

    logic [3:0]  dat [8];
    logic [6:0]  sb [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        i = '0;
        for (int k = 0; k < 8; k++) i[k*4 +: 4] = dat[k];
    end

    mux_rr_reg #(.width(4), .swidth(3)) dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .o(o), .o_ch(o_ch), .o_valid(o_valid), .o_ready(o_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check ready, score any beat being
    // consumed, queue the beat being loaded, then step past the rising edge.
    task automatic step(input string tag, input logic m, input logic [2:0] s,
                        input logic [7:0] v, input logic rdy, input logic [7:0] er,
                        input logic [3:0] eo, input logic [2:0] ech);
        logic [6:0] got;
        @(negedge clk);
        rst = 1'b0; mode = m; sel = s; in_valid = v; o_ready = rdy;
        #1;
        chk({tag, ".rdy"}, {8'h0, in_ready}, {8'h0, er});
        if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
                chk({tag, ".unexpected_beat"}, {9'h0, o, o_ch}, 16'hFFFF);
            end else begin
                got = sb.pop_front();
                chk({tag, ".beat"}, {9'h0, o, o_ch}, {9'h0, got});
            end
        end
        if ((er & v) != 8'h0) sb.push_back({eo, ech});
        @(posedge clk);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [3:0] eo, input logic [2:0] ech);
        #1;
        chk(tag, {8'h0, o_valid, o, o_ch}, {8'h0, ev, eo, ech});
    endtask

    initial begin
        for (int k = 0; k < 8; k++) dat[k] = 4'(k);
        rst = 1'b1; mode = 1'b0; sel = 3'd2; in_valid = 8'hFF; o_ready = 1'b1;
        repeat (2) @(posedge clk);
        check_out("reset_out", 1'b0, 4'h0, 3'd0);
        chk("reset_rdy", {8'h0, in_ready}, 16'h0);

        // Fixed select of channel 2 in the first cycle out of reset
        dat[2] = 4'hC;
        step("fixed_sel2", 1'b0, 3'd2, 8'hFF, 1'b1, 8'h04, 4'hC, 3'd2);
        check_out("fixed_out", 1'b1, 4'hC, 3'd2);
        dat[2] = 4'h2;
        step("fixed_drain", 1'b0, 3'd2, 8'h00, 1'b1, 8'h04, 4'h0, 3'd0);

        // Full round-robin sweep with wrap
        for (int k = 0; k < 9; k++)
            step("rr_sweep", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << (k % 8), 4'(k % 8), 3'(k % 8));
        check_out("rr_sweep_out", 1'b1, 4'h0, 3'd0);

        // Sparse requesters from ptr = 2: 7, 1, 7
        step("rr_to_ptr2", 1'b1, 3'd0, 8'h02, 1'b1, 8'h02, 4'h1, 3'd1);
        step("rr_sparse_a", 1'b1, 3'd0, 8'h82, 1'b1, 8'h80, 4'h7, 3'd7);
        step("rr_sparse_b", 1'b1, 3'd0, 8'h82, 1'b1, 8'h02, 4'h1, 3'd1);
        step("rr_sparse_c", 1'b1, 3'd0, 8'h82, 1'b1, 8'h80, 4'h7, 3'd7);

        // Backpressure hold then drain+load on one edge
        for (int k = 0; k < 3; k++) begin
            step("bp_hold", 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 4'h0, 3'd0);
            check_out("bp_hold_out", 1'b1, 4'h7, 3'd7);
        end
        step("bp_release", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 4'h0, 3'd0);
        check_out("bp_no_bubble", 1'b1, 4'h0, 3'd0);

        // Reset with a held beat discards it and restarts the scan at 0
        dat[1] = 4'hE;
        step("pre_reset", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 4'hE, 3'd1);
        check_out("pre_reset_out", 1'b1, 4'hE, 3'd1);
        dat[1] = 4'h1;
        @(negedge clk);
        rst = 1'b1; in_valid = 8'hFF; o_ready = 1'b1;
        #1;
        chk("midrst_rdy", {8'h0, in_ready}, 16'h0);
        @(posedge clk);
        check_out("midrst_out", 1'b0, 4'h0, 3'd0);
        sb.delete();
        step("post_rst_rr", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 4'h0, 3'd0);

        // Mode switch with ptr = 3: fixed sel 5 leaves ptr untouched
        step("to_ptr2", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 4'h1, 3'd1);
        step("to_ptr3", 1'b1, 3'd0, 8'hFF, 1'b1, 8'h04, 4'h2, 3'd2);
        step("fixed_sel5", 1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 4'h5, 3'd5);
        step("back_rr", 1'b1, 3'd5, 8'hFF, 1'b1, 8'h08, 4'h3, 3'd3);
        step("final_drain", 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 4'h0, 3'd0);
        check_out("drained_hold", 1'b0, 4'h3, 3'd3);
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
- REQ-001: Parameter `width`, default 4: data width per channel, in bits.
- REQ-002: Parameter `swidth`, default 3: select and channel-index width; channel count is N = 2**swidth.
- REQ-003: `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-004: `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-005: `i`, input, N*width bits: channel data, flat bus; channel k occupies bits [k*width +: width].
- REQ-006: `in_valid`, input, N bits: bit k set means channel k offers data.
- REQ-007: `in_ready`, output, N bits: bit k set means channel k's data is accepted this cycle.
- REQ-008: `sel`, input, swidth bits: channel index used in fixed mode.
- REQ-009: `mode`, input, 1 bit: 0 = fixed select, 1 = round-robin scan.
- REQ-010: `o`, output, width bits: registered output data.
- REQ-011: `o_ch`, output, swidth bits: index of the channel that supplied `o`.
- REQ-012: `o_valid`, output, 1 bit: `o` and `o_ch` hold valid data.
- REQ-013: `o_ready`, input, 1 bit: downstream accepts `o` this cycle.

Function
- REQ-014: `load_en` SHALL equal (!o_valid || o_ready) && !rst; the output register is empty or draining this cycle.
- REQ-015: Fixed mode SHALL define the grant as g = sel; `in_ready[sel]` SHALL equal `load_en`; all other `in_ready` bits SHALL be 0.
- REQ-016: Round-robin mode SHALL define the grant as the first k with `in_valid[k]` = 1, searching cyclically ptr, ptr+1, ..., ptr+N-1 (mod N).
- REQ-017: In round-robin mode, `in_ready[g]` SHALL equal `load_en`; all other bits SHALL be 0; with no valid channel, all bits SHALL be 0.
- REQ-018: A transfer SHALL occur when `in_valid[g]` && `in_ready[g]`; on the next edge o <= channel g data, o_ch <= g, o_valid <= 1. Latency is 1 cycle.
- REQ-019: Without a transfer, if o_valid && o_ready, then o_valid <= 0; `o` and `o_ch` SHALL hold their values.
- REQ-020: Without a transfer, if o_valid && !o_ready, then `o`, `o_ch` and `o_valid` SHALL all hold.
- REQ-021: A simultaneous drain and transfer (o_valid && o_ready plus a transfer) SHALL load the new data with o_valid staying 1; no bubble is allowed.
- REQ-022: On a transfer in round-robin mode, ptr <= (g+1) mod N; at g = N-1, ptr SHALL wrap to 0.
- REQ-023: `ptr` (swidth bits, internal) SHALL hold when there is no round-robin transfer, and SHALL hold in fixed mode.
- REQ-024: `mode` and `sel` SHALL be sampled combinationally each cycle; a change SHALL take effect on the grant in the same cycle. An output already registered SHALL NOT be altered.
- REQ-025: `in_ready` SHALL depend combinationally on `in_valid` in round-robin mode only.
- REQ-026: No combinational path SHALL exist from `i` to `o`.
- REQ-027: Channels not granted SHALL never see `in_ready` high.
- REQ-028: At most one `in_ready` bit SHALL be high in any cycle.

Reset
- REQ-029: While `rst` = 1, at each edge: o <= 0, o_ch <= 0, o_valid <= 0, ptr <= 0.
- REQ-030: While `rst` = 1, `in_ready` SHALL be all 0, so no transfer occurs.
- REQ-031: A reset asserted while o_valid = 1 SHALL discard the held data; no partial state SHALL survive.
- REQ-032: The first transfer after reset SHALL be possible in the first cycle with `rst` = 0.

Verification (width = 4, swidth = 3)
- REQ-033: Fixed mode, sel = 3'b010, i ch2 = 4'hC, in_valid = 8'hFF, o_ready = 1 -> in_ready = 8'h04; next cycle o = 4'hC, o_ch = 2, o_valid = 1.
- REQ-034: Round-robin mode, in_valid = 8'hFF, o_ready = 1 for 9 cycles after reset, channel k data = k -> o_ch sequence 0,1,...,7,0 and o = o_ch each cycle.
- REQ-035: Round-robin mode, in_valid = 8'b1000_0010, ptr = 2 -> grant 7, then grant 1, then grant 7; skipped channels never see ready.
- REQ-036: Backpressure: o_valid = 1, o_ready = 0 for 3 cycles -> in_ready = 0, o and o_ch held; o_ready = 1 with a valid channel -> drain and load on the same edge, o_valid stays 1.
- REQ-037: Reset mid-stream: o_valid = 1, o = 4'hE, rst = 1 for one cycle -> o = 0, o_valid = 0, o_ch = 0; the next round-robin grant starts from channel 0.
- REQ-038: Mode switch 1 -> 0 with sel = 3'b101 while ptr = 3 -> next grant is 5; after switching back to 1, ptr is still 3.
